// File: rtl/ntsc_sync_decoder.sv
// Composite NTSC receive-side sync slicer: recovers line/field timing from 12-bit samples,
// reports horizontal lock, raster position and black-referenced luma for the active picture.
module ntsc_sync_decoder #(
    parameter int          INVERT         = 1,
    parameter logic [11:0] SYNC_THRESH    = 12'h266,
    parameter logic [11:0] BLACK_LEVEL    = 12'h4CD,
    parameter int          LINE_LEN       = 910,
    parameter int          LINE_TOL       = 8,
    parameter int          HS_MIN         = 50,
    parameter int          HS_MAX         = 90,
    parameter int          VS_MIN         = 400,
    parameter int          ACT_START      = 136,
    parameter int          ACT_LEN        = 752,
    parameter int          ACT_LINE_START = 7,
    parameter int          ACT_LINES      = 244
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] sample_i,
    output logic        locked_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [9:0]  hpos_o,
    output logic [8:0]  line_o,
    output logic        active_o,
    output logic [9:0]  pixel_o,
    output logic [11:0] luma_o
);
    localparam logic [9:0] GOOD_LO = 10'(LINE_LEN - LINE_TOL - 1);
    localparam logic [9:0] GOOD_HI = 10'(LINE_LEN + LINE_TOL - 1);
    localparam logic [9:0] HALF    = 10'(LINE_LEN / 2);
    localparam logic [9:0] HS_LO   = 10'(HS_MIN);
    localparam logic [9:0] HS_HI   = 10'(HS_MAX);
    localparam logic [9:0] VS_LO   = 10'(VS_MIN);
    localparam logic [9:0] A_START = 10'(ACT_START);
    localparam logic [9:0] A_END   = 10'(ACT_START + ACT_LEN);
    localparam logic [8:0] L_START = 9'(ACT_LINE_START);
    localparam logic [8:0] L_END   = 9'(ACT_LINE_START + ACT_LINES);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t      state, state_next;
    logic [1:0]  good_cnt, good_cnt_next;
    logic [11:0] s1;
    logic        low, low_q;
    logic        fall, rise, edge_acc, good;
    logic        is_normal, is_broad, enter_search;
    logic [9:0]  hpos, width;
    logic [8:0]  line;
    logic [3:0]  broad_cnt;
    logic        pending_vs, last_normal;
    logic [11:0] luma_r;
    logic        hsync_r, vsync_r;
    logic        active;

    assign low  = (s1 < SYNC_THRESH);
    assign fall = low && !low_q;
    assign rise = !low && low_q;
    // Once locked, falling edges in the first half of a line are glitches (or
    // half-line pulses) and must neither restart the line nor count as bad spacing.
    assign edge_acc  = fall && ((state == SEARCH) || (hpos >= HALF));
    assign good      = (hpos >= GOOD_LO) && (hpos <= GOOD_HI);
    assign is_normal = (width >= HS_LO) && (width <= HS_HI);
    assign is_broad  = (width >= VS_LO);
    assign enter_search = (state == LOCKED) && (state_next == SEARCH);

    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        case (state)
            SEARCH: begin
                if (edge_acc) begin
                    if (!good) begin
                        good_cnt_next = 2'd0;
                    end else if (good_cnt == 2'd3) begin
                        good_cnt_next = 2'd0;
                        state_next    = LOCKED;
                    end else begin
                        good_cnt_next = good_cnt + 2'd1;
                    end
                end
            end
            LOCKED: begin
                if (edge_acc && !good) begin
                    state_next = SEARCH;
                end else if (!edge_acc && (hpos == GOOD_HI)) begin
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= SEARCH;
            good_cnt    <= 2'd0;
            s1          <= 12'd0;
            low_q       <= 1'b1;
            hpos        <= 10'd0;
            width       <= 10'd0;
            line        <= 9'd0;
            broad_cnt   <= 4'd0;
            pending_vs  <= 1'b0;
            last_normal <= 1'b0;
            luma_r      <= 12'd0;
            hsync_r     <= 1'b0;
            vsync_r     <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
            s1       <= (INVERT != 0) ? (12'hFFF - sample_i) : sample_i;
            low_q    <= low;
            luma_r   <= (s1 > BLACK_LEVEL) ? (s1 - BLACK_LEVEL) : 12'd0;

            if (edge_acc) begin
                hpos <= 10'd0;
            end else if (hpos != 10'h3FF) begin
                hpos <= hpos + 10'd1;
            end

            if (fall) begin
                width <= 10'd1;
            end else if (low && (width != 10'h3FF)) begin
                width <= width + 10'd1;
            end

            hsync_r <= edge_acc && (state_next == LOCKED) && last_normal;
            vsync_r <= edge_acc && pending_vs && !enter_search;

            if (rise && is_normal) begin
                last_normal <= 1'b1;
            end else if (rise && is_broad) begin
                last_normal <= 1'b0;
            end

            // Classification lands at the sync's rising edge, so line/vsync act one edge later.
            if (enter_search) begin
                line       <= 9'd0;
                broad_cnt  <= 4'd0;
                pending_vs <= 1'b0;
            end else begin
                if (edge_acc) begin
                    if (pending_vs) begin
                        line       <= 9'd0;
                        pending_vs <= 1'b0;
                    end else if (line != 9'h1FF) begin
                        line <= line + 9'd1;
                    end
                end
                if (rise && is_normal) begin
                    pending_vs <= (broad_cnt >= 4'd3);
                    broad_cnt  <= 4'd0;
                end else if (rise && is_broad) begin
                    pending_vs <= 1'b0;
                    if (broad_cnt != 4'hF) begin
                        broad_cnt <= broad_cnt + 4'd1;
                    end
                end
            end
        end
    end

    assign active = (state == LOCKED) && (line >= L_START) && (line < L_END)
                    && (hpos >= A_START) && (hpos < A_END);

    assign locked_o = (state == LOCKED);
    assign hsync_o  = hsync_r;
    assign vsync_o  = vsync_r;
    assign hpos_o   = hpos;
    assign line_o   = line;
    assign active_o = active;
    assign pixel_o  = active ? (hpos - A_START) : 10'd0;
    assign luma_o   = active ? luma_r : 12'd0;
endmodule

// File: tb/tb_ntsc_sync_decoder.sv
// Bench for ntsc_sync_decoder: directed composite lines with hand-derived expectations
// pushed into queues; a monitor pops them as the decoder presents events and pixels.
module tb_ntsc_sync_decoder;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [11:0] sample_i;
    logic        locked_o, hsync_o, vsync_o, active_o;
    logic [9:0]  hpos_o, pixel_o;
    logic [8:0]  line_o;
    logic [11:0] luma_o;

    int total = 0;
    int bad   = 0;
    int g_line = 0;
    int cur_line = 0;
    logic mon_en = 1'b0;
    logic prev_locked = 1'b0;

    logic [15:0] hs_q[$];
    logic [15:0] vs_q[$];
    logic [26:0] lock_q[$];
    logic [30:0] exp_q[$];

    ntsc_sync_decoder dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sample_i (sample_i),
        .locked_o (locked_o),
        .hsync_o  (hsync_o),
        .vsync_o  (vsync_o),
        .hpos_o   (hpos_o),
        .line_o   (line_o),
        .active_o (active_o),
        .pixel_o  (pixel_o),
        .luma_o   (luma_o)
    );

    always #35 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (stream line %0d)", name, got, exp, cur_line);
        end
    endtask

    // Un-inverted level at position p of a line whose sync starts at sample 22.
    function automatic logic [11:0] level_at(input int p, input int sw, input bit glitch, input int pat);
        int pix;
        if (p >= 22 && p < 22 + sw) return 12'h000;
        if (glitch && p >= 400 && p < 420) return 12'h000;
        if (p >= 158 && pat != 0) begin
            pix = p - 158;
            if (pat == 1) begin
                if (pix < 250) return 12'h4CD;
                if (pix < 500) return 12'hFFF;
                return 12'h400;
            end
            return 12'(32'h4CD + pix);
        end
        return 12'h4CD;
    endfunction

    function automatic logic [11:0] luma_of(input logic [11:0] lvl);
        return (lvl > 12'h4CD) ? (lvl - 12'h4CD) : 12'h000;
    endfunction

    task automatic drive_line(input int len, input int sw, input bit glitch, input int pat,
                              input int exp_line, input bit exp_hs, input int nsamp);
        if (exp_hs) hs_q.push_back(16'(g_line));
        if (exp_line >= 0) begin
            for (int pix = 0; pix < 752; pix++) begin
                exp_q.push_back({9'(exp_line), 10'(pix), luma_of(level_at(158 + pix, sw, glitch, pat))});
            end
        end
        for (int p = 0; p < nsamp && p < len; p++) begin
            @(negedge clk_i);
            if (p == 0) cur_line = g_line;
            sample_i = 12'hFFF - level_at(p, sw, glitch, pat);
        end
        g_line++;
    endtask

    // Monitor: pops expectations whenever the decoder presents an event or a pixel.
    always begin
        logic [15:0] e16;
        logic [26:0] el;
        logic [30:0] ea;
        @(posedge clk_i);
        #1;
        if (mon_en) begin
            if (hsync_o) begin
                chk("hsync_expected", 32'(hs_q.size() != 0), 1);
                if (hs_q.size() != 0) begin
                    e16 = hs_q.pop_front();
                    chk("hsync_line", 32'(cur_line), 32'(e16));
                    chk("hsync_hpos", 32'(hpos_o), 0);
                end
            end
            if (vsync_o) begin
                chk("vsync_expected", 32'(vs_q.size() != 0), 1);
                if (vs_q.size() != 0) begin
                    e16 = vs_q.pop_front();
                    chk("vsync_line", 32'(cur_line), 32'(e16));
                    chk("vsync_line_o", 32'(line_o), 0);
                    chk("vsync_hpos", 32'(hpos_o), 0);
                end
            end
            if (locked_o != prev_locked) begin
                chk("lock_change_expected", 32'(lock_q.size() != 0), 1);
                if (lock_q.size() != 0) begin
                    el = lock_q.pop_front();
                    chk("lock_value", 32'(locked_o), 32'(el[26]));
                    chk("lock_line", 32'(cur_line), 32'(el[25:10]));
                    chk("lock_hpos", 32'(hpos_o), 32'(el[9:0]));
                end
            end
            if (active_o) begin
                chk("active_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    ea = exp_q.pop_front();
                    chk("active_line", 32'(line_o), 32'(ea[30:22]));
                    chk("active_pixel", 32'(pixel_o), 32'(ea[21:12]));
                    chk("active_luma", 32'(luma_o), 32'(ea[11:0]));
                end
            end else begin
                chk("idle_pixel_luma", {10'd0, pixel_o, luma_o}, 0);
            end
        end
        prev_locked = locked_o;
    end

    initial begin
        rst_i    = 1'b1;
        sample_i = 12'hFFF - 12'h4CD;
        repeat (4) @(negedge clk_i);
        chk("reset_locked", 32'(locked_o), 0);
        chk("reset_hpos", 32'(hpos_o), 0);
        chk("reset_line", 32'(line_o), 0);
        chk("reset_active", 32'(active_o), 0);
        rst_i  = 1'b0;
        mon_en = 1'b1;

        lock_q.push_back({1'b1, 16'd4, 10'd0});
        lock_q.push_back({1'b0, 16'd25, 10'd918});
        lock_q.push_back({1'b1, 16'd30, 10'd0});
        vs_q.push_back(16'd8);

        // Field start: 7 broad lines (lock lands on the 5th sync), then normal lines.
        for (int i = 0; i < 7; i++) drive_line(910, 843, 1'b0, 0, (i == 6) ? 7 : -1, 1'b0, 910);
        drive_line(910, 67, 1'b0, 0, 8, 1'b0, 910);
        for (int i = 0; i < 7; i++) drive_line(910, 67, 1'b0, 0, -1, 1'b1, 910);
        drive_line(910, 67, 1'b0, 1, 7, 1'b1, 910);
        drive_line(910, 67, 1'b0, 2, 8, 1'b1, 910);
        drive_line(910, 67, 1'b0, 0, 9, 1'b1, 910);
        // A two-line broad run must not produce a vertical sync.
        drive_line(910, 843, 1'b0, 0, 10, 1'b1, 910);
        drive_line(910, 843, 1'b0, 0, 11, 1'b0, 910);
        drive_line(910, 67, 1'b0, 0, 12, 1'b0, 910);
        drive_line(910, 67, 1'b0, 0, 13, 1'b1, 910);
        drive_line(910, 67, 1'b1, 0, 14, 1'b1, 910);
        drive_line(910, 67, 1'b0, 0, 15, 1'b1, 910);
        drive_line(910, 67, 1'b0, 0, 16, 1'b1, 910);
        // Missing sync, then reacquisition.
        drive_line(910, 0, 1'b0, 0, -1, 1'b0, 910);
        for (int i = 0; i < 4; i++) drive_line(910, 67, 1'b0, 0, -1, 1'b0, 910);
        drive_line(910, 67, 1'b0, 0, -1, 1'b1, 910);
        drive_line(910, 67, 1'b0, 0, -1, 1'b1, 910);
        drive_line(910, 67, 1'b0, 0, -1, 1'b1, 100);

        @(negedge clk_i);
        chk("midline_locked", 32'(locked_o), 1);
        chk("midline_line", 32'(line_o), 7);
        mon_en = 1'b0;
        rst_i  = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_locked", 32'(locked_o), 0);
        chk("rst_hsync", 32'(hsync_o), 0);
        chk("rst_vsync", 32'(vsync_o), 0);
        chk("rst_hpos", 32'(hpos_o), 0);
        chk("rst_line", 32'(line_o), 0);
        chk("rst_active", 32'(active_o), 0);
        chk("rst_pixel", 32'(pixel_o), 0);
        chk("rst_luma", 32'(luma_o), 0);
        @(negedge clk_i);
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Off-nominal 930-clock lines: no lock, hsync or picture may appear.
        for (int i = 0; i < 8; i++) drive_line(930, 67, 1'b0, 0, -1, 1'b0, 930);
        repeat (10) @(negedge clk_i);
        chk("long_lines_locked", 32'(locked_o), 0);
        chk("hs_q_drained", 32'(hs_q.size()), 0);
        chk("vs_q_drained", 32'(vs_q.size()), 0);
        chk("lock_q_drained", 32'(lock_q.size()), 0);
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
